// File: rtl/dmem_pkg.sv
// dmem_pkg: access-size encodings, controller states, load-latency limits and
// byte-lane helpers shared by the dmem_sized data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // Byte-lane write enables; a half only looks at lane[1], anything wider is a word.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << lane;
            SZ_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Natural-alignment rule used when alignment checking is built in.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lane[0];
            SZ_WORD: is_misaligned = (lane != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sized_if.sv
// dmem_sized_if: request/response bus between the load/store unit (master)
// and the data memory (slave).
interface dmem_sized_if;
    logic        DMEM_req;
    logic        DMEM_we;
    logic [1:0]  DMEM_size;
    logic        DMEM_unsigned;
    logic [31:0] DMEM_address;
    logic [31:0] DMEM_data_in;
    logic        DMEM_ready;
    logic        DMEM_rvalid;
    logic [31:0] DMEM_data_out;
    logic        DMEM_err;

    modport master (
        output DMEM_req, DMEM_we, DMEM_size, DMEM_unsigned, DMEM_address, DMEM_data_in,
        input  DMEM_ready, DMEM_rvalid, DMEM_data_out, DMEM_err
    );

    modport slave (
        input  DMEM_req, DMEM_we, DMEM_size, DMEM_unsigned, DMEM_address, DMEM_data_in,
        output DMEM_ready, DMEM_rvalid, DMEM_data_out, DMEM_err
    );
endinterface

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: picks the addressed byte/half out of a read word, moves it to
// bit 0 and sign- or zero-extends it to 32 bits. Reserved size reads as word.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select, then extension by access size.
    always_comb begin
        case (i_lane)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
        case (i_size)
            SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/dmem_sized.sv
// dmem_sized: word-organised data memory with byte/half/word access, byte-lane
// stores, an RD_LAT-deep load pipeline and a zero-fill sweep after reset.
// Optional alignment checking: define DMEM_ALIGN_CHECK_EN.
//
// state   | meaning
// ST_INIT | zero-fill sweep, one word per cycle, requests ignored
// ST_RUN  | ready high, one load or store accepted per cycle
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int RD_LAT     = 1
) (
    input  logic         DMEM_clk,
    input  logic         DMEM_rst_n,
    dmem_sized_if.slave  bus
);

    // Out-of-range latencies are clamped rather than producing a broken pipe.
    localparam int LAT   = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                           (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] SWEEP_LAST = '1;

    typedef struct packed {
        logic        ld;     // produces an rvalid pulse
        logic        er;     // misaligned access, produces an err pulse
        logic [31:0] word;
        logic [1:0]  lane;
        logic [1:0]  size;
        logic        uns;
    } stage_t;

    state_t                r_state;
    logic [DEPTH_LOG2-1:0] r_sweep;
    logic                  r_ready;
    logic                  r_rvalid;
    logic                  r_err;
    logic [31:0]           r_data_out;
    stage_t                r_pipe [LAT];
    logic [31:0]           r_mem  [DEPTH];

    logic                  w_acc;
    logic                  w_mis;
    logic [1:0]            w_lane;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [DEPTH_LOG2-1:0] w_widx;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_ext;
    stage_t                w_stage_in;
    logic                  w_unused;

    assign w_acc    = bus.DMEM_req & r_ready;
    assign w_lane   = bus.DMEM_address[1:0];
    assign w_idx    = bus.DMEM_address[DEPTH_LOG2+1:2];
    assign w_unused = ^bus.DMEM_address[31:DEPTH_LOG2+2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_mis = is_misaligned(bus.DMEM_size, w_lane);
`else
    assign w_mis = 1'b0;
`endif

    // Write port: the sweep owns it in INIT, accepted aligned stores in RUN.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = '0;
        w_widx  = w_idx;
        if (r_state == ST_INIT) begin
            w_be   = 4'b1111;
            w_widx = r_sweep;
        end else if (w_acc && bus.DMEM_we && !w_mis) begin
            w_be = lane_mask(bus.DMEM_size, w_lane);
            case (bus.DMEM_size)
                SZ_BYTE: w_wdata = {4{bus.DMEM_data_in[7:0]}};
                SZ_HALF: w_wdata = {2{bus.DMEM_data_in[15:0]}};
                default: w_wdata = bus.DMEM_data_in;
            endcase
        end
    end

    // Byte-lane writes into the storage array (not reset; the sweep clears it).
    always_ff @(posedge DMEM_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
                r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    // Head of the load pipe: the whole word is captured at the accept edge,
    // so a store on the previous edge is already visible.
    always_comb begin
        w_stage_in = '0;
        if (w_acc) begin
            w_stage_in.ld   = ~bus.DMEM_we;
            w_stage_in.er   = w_mis;
            w_stage_in.word = r_mem[w_idx];
            w_stage_in.lane = w_lane;
            w_stage_in.size = bus.DMEM_size;
            w_stage_in.uns  = bus.DMEM_unsigned;
        end
    end

    dmem_load_ext u_load_ext (
        .i_word     (r_pipe[LAT-1].word),
        .i_lane     (r_pipe[LAT-1].lane),
        .i_size     (r_pipe[LAT-1].size),
        .i_unsigned (r_pipe[LAT-1].uns),
        .o_data     (w_ext)
    );

    // Controller FSM: sweep counter and the registered ready flag.
    always_ff @(posedge DMEM_clk or negedge DMEM_rst_n) begin
        if (!DMEM_rst_n) begin
            r_state <= ST_INIT;
            r_sweep <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_sweep <= r_sweep + 1'b1;
                    if (r_sweep == SWEEP_LAST) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                default: r_ready <= 1'b1;
            endcase
        end
    end

    // Load pipeline and response registers; reset drops everything in flight.
    always_ff @(posedge DMEM_clk or negedge DMEM_rst_n) begin
        if (!DMEM_rst_n) begin
            for (int s = 0; s < LAT; s++) begin
                r_pipe[s] <= '0;
            end
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_pipe[0] <= w_stage_in;
            for (int s = 1; s < LAT; s++) begin
                r_pipe[s] <= r_pipe[s-1];
            end
            r_rvalid <= r_pipe[LAT-1].ld;
            r_err    <= r_pipe[LAT-1].er;
            if (r_pipe[LAT-1].ld) begin
                r_data_out <= r_pipe[LAT-1].er ? 32'h0 : w_ext;
            end
        end
    end

    assign bus.DMEM_ready    = r_ready;
    assign bus.DMEM_rvalid   = r_rvalid;
    assign bus.DMEM_err      = r_err;
    assign bus.DMEM_data_out = r_data_out;

endmodule

// File: tb/tb_dmem_sized.sv
// tb_dmem_sized: drives RD_LAT=1 and RD_LAT=3 instances with identical traffic
// and checks both against a byte-addressed reference memory.
module tb_dmem_sized;
    import dmem_pkg::*;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam int NCYC = 16384;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dmem_sized_if if1 ();
    dmem_sized_if if3 ();

    dmem_sized #(.DEPTH_LOG2(8), .RD_LAT(1)) u_dut1 (
        .DMEM_clk   (clk),
        .DMEM_rst_n (rst_n),
        .bus        (if1)
    );

    dmem_sized #(.DEPTH_LOG2(8), .RD_LAT(3)) u_dut3 (
        .DMEM_clk   (clk),
        .DMEM_rst_n (rst_n),
        .bus        (if3)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    bit          exp_ready = 1'b0;
    logic [7:0]  mb [1024];
    bit          ev_ld  [2][NCYC];
    bit          ev_er  [2][NCYC];
    logic [31:0] ev_dat [2][NCYC];
    logic [31:0] exp_do [2];
    int          log_cyc [$];
    logic [31:0] log_dat [$];

    typedef struct packed {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] d;
        logic        chk;
        logic [31:0] exp;
    } vec_t;
    vec_t tv [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    task automatic mon(input int d, input logic rdy, input logic rv, input logic er,
                       input logic [31:0] dout);
        int s;
        s = cyc % NCYC;
        if (ev_ld[d][s]) exp_do[d] = ev_dat[d][s];
        check($sformatf("ready dut%0d", d), 32'(rdy), 32'(exp_ready));
        check($sformatf("rvalid dut%0d", d), 32'(rv), 32'(ev_ld[d][s]));
        check($sformatf("err dut%0d", d), 32'(er), 32'(ev_er[d][s]));
        check($sformatf("data_out dut%0d", d), dout, exp_do[d]);
        ev_ld[d][s] = 1'b0;
        ev_er[d][s] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cyc >= NCYC - 8) begin
            $display("FAIL watchdog: cycle %0d, limit %0d", cyc, NCYC - 8);
            $fatal(1, "cycle budget exhausted");
        end
        mon(0, if1.DMEM_ready, if1.DMEM_rvalid, if1.DMEM_err, if1.DMEM_data_out);
        mon(1, if3.DMEM_ready, if3.DMEM_rvalid, if3.DMEM_err, if3.DMEM_data_out);
        if (if3.DMEM_rvalid === 1'b1) begin
            log_cyc.push_back(cyc);
            log_dat.push_back(if3.DMEM_data_out);
        end
    end

    task automatic post(input int c, input bit ld, input bit er, input logic [31:0] v);
        ev_ld[0][(c + 1) % NCYC]  = ld;
        ev_er[0][(c + 1) % NCYC]  = er;
        ev_dat[0][(c + 1) % NCYC] = v;
        ev_ld[1][(c + 3) % NCYC]  = ld;
        ev_er[1][(c + 3) % NCYC]  = er;
        ev_dat[1][(c + 3) % NCYC] = v;
    endtask

    // Reference: little-endian byte memory; halves start at the even byte,
    // words (and reserved size) at the word boundary.
    task automatic accept(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d);
        int ba, base, n;
        bit mis;
        logic [31:0] v;
        ba   = int'(a[9:0]);
        mis  = ALIGN && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || sz == 2'd3);
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = (n == 1) ? ba : (n == 2) ? (ba & 'h3FE) : (ba & 'h3FC);
        if (we) begin
            if (mis) post(cyc, 1'b0, 1'b1, 32'h0);
            else for (int i = 0; i < n; i++) mb[base + i] = d[8*i +: 8];
        end else begin
            v = 32'h0;
            if (!mis) begin
                for (int i = 0; i < n; i++) v = v | (32'(mb[base + i]) << (8 * i));
                if (!uns && n < 4 && v[8*n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
            end
            post(cyc, 1'b1, mis, v);
        end
    endtask

    task automatic set_pins(input logic req, input logic we, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a, input logic [31:0] d);
        if1.DMEM_req = req; if1.DMEM_we = we; if1.DMEM_size = sz;
        if1.DMEM_unsigned = uns; if1.DMEM_address = a; if1.DMEM_data_in = d;
        if3.DMEM_req = req; if3.DMEM_we = we; if3.DMEM_size = sz;
        if3.DMEM_unsigned = uns; if3.DMEM_address = a; if3.DMEM_data_in = d;
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d);
        bit rdy;
        rdy = exp_ready;
        set_pins(1'b1, we, sz, uns, a, d);
        @(posedge clk);
        #1;
        if (rdy) accept(we, sz, uns, a, d);
    endtask

    task automatic idle();
        set_pins(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_ready = 1'b0;
        exp_do[0] = 32'h0;
        exp_do[1] = 32'h0;
        for (int c = 0; c < 6; c++) begin
            for (int d = 0; d < 2; d++) begin
                ev_ld[d][(cyc + c) % NCYC] = 1'b0;
                ev_er[d][(cyc + c) % NCYC] = 1'b0;
            end
        end
        for (int i = 0; i < 1024; i++) mb[i] = 8'h0;
    endtask

    // Called right after reset release; requests hammer word 0 during the sweep.
    task automatic sweep_check();
        for (int i = 1; i <= 256; i++) begin
            set_pins(i < 256, i[0], SZ_WORD, 1'b0, 32'h0, 32'hDEADBEEF);
            @(posedge clk);
            #1;
            if (i == 256) exp_ready = 1'b1;
            check("sweep ready dut1", 32'(if1.DMEM_ready), 32'(i == 256));
            check("sweep ready dut3", 32'(if3.DMEM_ready), 32'(i == 256));
        end
        set_pins(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic add(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d, input logic chk,
                       input logic [31:0] exp);
        tv.push_back({we, sz, uns, a, d, chk, exp});
    endtask

    initial begin
        int k;
        logic [31:0] ra, rd;
        logic [1:0] rsz;
        logic rwe, runs;

        set_pins(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        exp_do[0] = 32'h0;
        exp_do[1] = 32'h0;
        #1;
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep_check();

        add(0, SZ_WORD, 0, 32'h40, 32'h0, 1, 32'h0000_0000);
        add(0, SZ_WORD, 0, 32'h0,  32'h0, 1, 32'h0000_0000);
        add(1, SZ_WORD, 0, 32'h10, 32'h8899AABB, 0, 32'h0);
        add(0, SZ_BYTE, 0, 32'h13, 32'h0, 1, 32'hFFFF_FF88);
        add(0, SZ_BYTE, 1, 32'h13, 32'h0, 1, 32'h0000_0088);
        add(0, SZ_HALF, 0, 32'h10, 32'h0, 1, 32'hFFFF_AABB);
        add(0, SZ_HALF, 1, 32'h12, 32'h0, 1, 32'h0000_8899);
        add(1, SZ_WORD, 0, 32'h20, 32'h11223344, 0, 32'h0);
        add(1, SZ_BYTE, 0, 32'h21, 32'hFFFFFF5A, 0, 32'h0);
        add(0, SZ_WORD, 0, 32'h20, 32'h0, 1, 32'h1122_5A44);
        add(0, SZ_BYTE, 1, 32'h21, 32'h0, 1, 32'h0000_005A);
        add(1, SZ_WORD, 0, 32'h30, 32'h01020304, 0, 32'h0);
        add(1, SZ_HALF, 0, 32'h32, 32'h1234BEEF, 0, 32'h0);
        add(0, SZ_WORD, 0, 32'h30, 32'h0, 1, 32'hBEEF_0304);
        add(0, SZ_BYTE, 0, 32'h31, 32'h0, 1, 32'h0000_0003);
        add(0, SZ_WORD, 0, 32'hFFFF_F030, 32'h0, 1, 32'hBEEF_0304);
        add(0, SZ_WORD, 0, 32'h22, 32'h0, 1, ALIGN ? 32'h0 : 32'h1122_5A44);
        add(1, SZ_HALF, 0, 32'h31, 32'h0000FFFF, 0, 32'h0);
        add(0, SZ_WORD, 0, 32'h30, 32'h0, 1, ALIGN ? 32'hBEEF_0304 : 32'hBEEF_FFFF);
        add(0, SZ_RSVD, 0, 32'h20, 32'h0, 1, ALIGN ? 32'h0 : 32'h1122_5A44);
        add(0, SZ_HALF, 0, 32'h23, 32'h0, 1, ALIGN ? 32'h0 : 32'h0000_1122);
        add(1, SZ_WORD, 0, 32'h100, 32'hA0000001, 0, 32'h0);
        add(1, SZ_WORD, 0, 32'h104, 32'hA0000002, 0, 32'h0);
        add(1, SZ_WORD, 0, 32'h108, 32'hA0000003, 0, 32'h0);
        add(1, SZ_WORD, 0, 32'h10C, 32'hA0000004, 0, 32'h0);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].we, tv[i].sz, tv[i].uns, tv[i].a, tv[i].d);
            repeat (4) idle();
            if (tv[i].chk) begin
                check($sformatf("vec%0d data dut1", i), if1.DMEM_data_out, tv[i].exp);
                check($sformatf("vec%0d data dut3", i), if3.DMEM_data_out, tv[i].exp);
            end
        end

        // Four back-to-back loads on the RD_LAT=3 instance.
        log_cyc.delete();
        log_dat.delete();
        drive(0, SZ_WORD, 0, 32'h100, 32'h0);
        k = cyc;
        drive(0, SZ_WORD, 0, 32'h104, 32'h0);
        drive(0, SZ_WORD, 0, 32'h108, 32'h0);
        drive(0, SZ_WORD, 0, 32'h10C, 32'h0);
        repeat (6) idle();
        check("b2b pulse count", 32'(log_cyc.size()), 32'd4);
        for (int i = 0; i < log_cyc.size() && i < 4; i++) begin
            check($sformatf("b2b cycle %0d", i), 32'(log_cyc[i]), 32'(k + 3 + i));
            check($sformatf("b2b data %0d", i), log_dat[i], 32'hA0000001 + 32'(i));
        end

        // Reset one cycle after a load is accepted.
        log_cyc.delete();
        drive(0, SZ_WORD, 0, 32'h104, 32'h0);
        do_reset();
        #1;
        check("rst rvalid dut1", 32'(if1.DMEM_rvalid), 32'd0);
        check("rst rvalid dut3", 32'(if3.DMEM_rvalid), 32'd0);
        check("rst data dut1", if1.DMEM_data_out, 32'h0);
        check("rst data dut3", if3.DMEM_data_out, 32'h0);
        check("rst ready dut1", 32'(if1.DMEM_ready), 32'd0);
        check("rst ready dut3", 32'(if3.DMEM_ready), 32'd0);
        set_pins(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep_check();
        check("rst dropped load", 32'(log_cyc.size()), 32'd0);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle();
            end else begin
                rwe  = 1'($urandom_range(0, 1));
                rsz  = 2'($urandom_range(0, 3));
                runs = 1'($urandom_range(0, 1));
                ra   = ($urandom() & 32'hFFFF_FC00) |
                       (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1023))
                                                    : 32'($urandom_range(0, 63)));
                rd   = $urandom();
                drive(rwe, rsz, runs, ra, rd);
            end
        end
        repeat (6) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
